// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//   Instruction-packet queue between FetchStage2 and Decode. Each cycle it
//   accepts up to FETCH_W packets, drops the invalid slots so that the valid
//   ones land in consecutive entries of a circular buffer (program order), and
//   presents the DISPATCH_W oldest entries to Decode. It is emptied on branch
//   recovery (flush_i) and by reset.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   flush_i        recovery flush; empties the queue, drops same-cycle bundle
//   fs2Ready_i     FetchStage2 bundle valid this cycle
//   instValid_i    per-slot valid, slot 0 = oldest
//   instPkt_i      slot k packet at [(k+1)*PKT_W-1 : k*PKT_W]
//   stall_o        fewer than FETCH_W free entries; Fetch must hold its bundle
//   outValid_o     prefix mask of valid output slots, slot 0 = oldest
//   outPkt_o       oldest packets, same slot packing as the input
//   decodeReady_i  Decode consumes every valid output slot this cycle
//   count_o        current occupancy
// -----------------------------------------------------------------------------
module fetch_decode_queue #(
  parameter int PKT_W      = 133,
  parameter int FETCH_W    = 4,
  parameter int DISPATCH_W = 4,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          fs2Ready_i,
  input  logic [FETCH_W-1:0]            instValid_i,
  input  logic [FETCH_W*PKT_W-1:0]      instPkt_i,
  output logic                          stall_o,
  output logic [DISPATCH_W-1:0]         outValid_o,
  output logic [DISPATCH_W*PKT_W-1:0]   outPkt_o,
  input  logic                          decodeReady_i,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic [CW-1:0]    w_free;
  logic             w_stall;
  logic             w_wr_en;
  logic [CW-1:0]    w_nwr;
  logic [CW-1:0]    w_nwr_eff;
  logic [CW-1:0]    w_nrd;
  logic [PW-1:0]    w_wr_off [FETCH_W];

  // Write-side compaction and read-side amount.
  // NOTE: always_comb uses blocking '=' and assigns every output first, so the
  // running popcount below reads its own updated value and no latch is inferred.
  always_comb begin
    w_free    = CW'(DEPTH) - r_count;
    // Conservative: same-cycle dequeue is not credited.
    w_stall   = w_free < CW'(FETCH_W);
    w_wr_en   = fs2Ready_i & ~w_stall & ~flush_i;
    w_nwr     = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      // Slot k lands after all valid lower-numbered slots.
      w_wr_off[k] = w_nwr[PW-1:0];
      w_nwr       = w_nwr + CW'(instValid_i[k]);
    end
    w_nwr_eff = w_wr_en ? w_nwr : '0;
    w_nrd     = '0;
    if (decodeReady_i && !flush_i) begin
      w_nrd = (r_count > CW'(DISPATCH_W)) ? CW'(DISPATCH_W) : r_count;
    end
  end

  // Pointer and occupancy state. Reset outranks flush, flush outranks traffic.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Advances stay below DEPTH, so PW-bit addition wraps modulo DEPTH.
      r_tail  <= r_tail + w_nwr_eff[PW-1:0];
      r_head  <= r_head + w_nrd[PW-1:0];
      r_count <= r_count + w_nwr_eff - w_nrd;
    end
  end

  // NOTE: packet storage has no reset; entries are only observed once counted
  // as occupied, so their power-up contents never matter.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (instValid_i[k]) begin
          r_mem[r_tail + w_wr_off[k]] <= instPkt_i[k*PKT_W +: PKT_W];
        end
      end
    end
  end

  always_comb begin
    outValid_o = '0;
    outPkt_o   = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      outValid_o[k]                  = (r_count > CW'(k)) & ~flush_i;
      outPkt_o[k*PKT_W +: PKT_W]     = r_mem[r_head + PW'(k)];
    end
  end

  assign stall_o = w_stall;
  assign count_o = r_count;

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    r_count <= CW'(DEPTH));
  a_valid_prefix: assert property (@(posedge clk)
    ((outValid_o + DISPATCH_W'(1)) & outValid_o) == '0);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_queue
//   Drives directed scenarios followed by random traffic into the queue. A
//   behavioural model (a plain queue of packets) is updated at every rising
//   edge from the applied inputs; a monitor compares the DUT outputs against
//   it on every falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_decode_queue;

  localparam int PKT_W      = 133;
  localparam int FETCH_W    = 4;
  localparam int DISPATCH_W = 4;
  localparam int DEPTH      = 16;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        flush_i;
  logic                        fs2Ready_i;
  logic [FETCH_W-1:0]          instValid_i;
  logic [FETCH_W*PKT_W-1:0]    instPkt_i;
  logic                        stall_o;
  logic [DISPATCH_W-1:0]       outValid_o;
  logic [DISPATCH_W*PKT_W-1:0] outPkt_o;
  logic                        decodeReady_i;
  logic [4:0]                  count_o;

  fetch_decode_queue #(
    .PKT_W(PKT_W), .FETCH_W(FETCH_W), .DISPATCH_W(DISPATCH_W), .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .fs2Ready_i    (fs2Ready_i),
    .instValid_i   (instValid_i),
    .instPkt_i     (instPkt_i),
    .stall_o       (stall_o),
    .outValid_o    (outValid_o),
    .outPkt_o      (outPkt_o),
    .decodeReady_i (decodeReady_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int seq      = 0;

  // Reference model: packets in program order, oldest at index 0.
  logic [PKT_W-1:0] model_q[$];

  task automatic check(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] new_pkt();
    logic [191:0] r;
    seq++;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, 32'(seq)};
    return r[PKT_W-1:0];
  endfunction

  // Apply one cycle of stimulus, then move just past the next rising edge.
  task automatic drive(input logic rdy, input logic [3:0] vld, input logic dr,
                       input logic fl, input logic rst);
    fs2Ready_i    = rdy;
    instValid_i   = vld;
    decodeReady_i = dr;
    flush_i       = fl;
    reset         = rst;
    for (int k = 0; k < FETCH_W; k++) instPkt_i[k*PKT_W +: PKT_W] = new_pkt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
  endtask

  // Model update (rising edge) and output comparison (falling edge).
  initial begin : monitor
    int sz;
    int nrd;
    bit full_m;
    logic [DISPATCH_W-1:0] exp_v;
    forever begin
      @(posedge clk);
      if (reset || flush_i) begin
        model_q.delete();
      end else begin
        sz     = model_q.size();
        full_m = (DEPTH - sz) < FETCH_W;
        nrd    = decodeReady_i ? ((sz < DISPATCH_W) ? sz : DISPATCH_W) : 0;
        for (int i = 0; i < nrd; i++) void'(model_q.pop_front());
        if (fs2Ready_i && !full_m) begin
          for (int k = 0; k < FETCH_W; k++)
            if (instValid_i[k]) model_q.push_back(instPkt_i[k*PKT_W +: PKT_W]);
        end
      end
      @(negedge clk);
      sz = model_q.size();
      check("count", 160'(count_o), 160'(sz));
      check("stall", 160'(stall_o), 160'((DEPTH - sz) < FETCH_W));
      exp_v = '0;
      for (int k = 0; k < DISPATCH_W; k++) exp_v[k] = (k < sz) && !flush_i;
      check("out_valid", 160'(outValid_o), 160'(exp_v));
      for (int k = 0; k < DISPATCH_W; k++) begin
        if (exp_v[k])
          check($sformatf("pkt%0d", k), 160'(outPkt_o[k*PKT_W +: PKT_W]),
                160'(model_q[k]));
      end
    end
  end

  initial begin : stimulus
    fs2Ready_i = 1'b0; instValid_i = '0; decodeReady_i = 1'b0;
    flush_i = 1'b0; reset = 1'b1; instPkt_i = '0;
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Single full bundle, held in the queue.
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    idle(2);
    drain(2);

    // Two sparse bundles compact into consecutive entries.
    drive(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
    idle(1);
    drain(3);

    // Fill to full; the extra bundle is refused; one dequeue frees room.
    for (int i = 0; i < 4; i++) drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    drain(1);
    idle(1);
    drain(4);

    // Wrap: move head=tail to 14, then stream across the boundary.
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
    drain(4);
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    drain(2);

    // Flush with offered bundle and Decode ready at count=9.
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0);
    idle(1);
    drain(1);

    // Reset with count=7 and a bundle offered.
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, 4'($urandom), ($urandom % 3) == 0,
            ($urandom % 40) == 0, ($urandom % 150) == 0);
    end
    drain(5);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
